// File: rtl/spi_xfer_ctrl_if.sv
// Host/clock-generator side bundle for the SPI transfer sequencer.
// Latency: wiring only.
// Backpressure: start is honoured only while ready is high; strobes are never stalled.
// Ports:
//   master : request (start/abort/tx_data/char_len/lsb_first), strobes (shift/sample), miso
//   slave  : ready, cs_n, tip, mosi, rx_data, done
interface spi_xfer_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
);
  logic                  start;
  logic                  abort;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [CNT_WIDTH-1:0]  char_len;
  logic                  lsb_first;
  logic                  shift;
  logic                  sample;
  logic                  miso;
  logic                  ready;
  logic                  cs_n;
  logic                  tip;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  done;

  modport master (
    output start, abort, tx_data, char_len, lsb_first, shift, sample, miso,
    input  ready, cs_n, tip, mosi, rx_data, done
  );

  modport slave (
    input  start, abort, tx_data, char_len, lsb_first, shift, sample, miso,
    output ready, cs_n, tip, mosi, rx_data, done
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI word-transfer sequencer: latches a request, drives cs_n/tip, shifts mosi, collects miso.
// Latency: start->tip 2 cycles, last sample->done 2 cycles (SETUP/HOLD stretch with SPI_CS_GUARD_EN).
// Backpressure: ready low while busy; start is dropped (not queued) when ready is low.
// Ports: sys_clk, rst (async, active-high), bus (spi_xfer_ctrl_if.slave).
// Optional: define SPI_CS_GUARD_EN to hold SETUP and HOLD for GUARD_CYCLES cycles each.
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = 6,
  parameter int GUARD_CYCLES = 4
) (
  input  logic           sys_clk,
  input  logic           rst,
  spi_xfer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_e;

  localparam logic [CNT_WIDTH-1:0] DW_LEN = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] tx_q, shadow_q, rx_data_q;
  logic [CNT_WIDTH-1:0]  len_q, smp_cnt_q, shf_cnt_q;
  logic                  lsb_q, ready_q, cs_n_q, tip_q, mosi_q, done_q;

  logic [CNT_WIDTH-1:0]  len_d, first_pos_d, smp_pos_d, shf_pos_d, smp_cnt_d, shf_cnt_d;
  logic [DATA_WIDTH-1:0] first_word_d, shf_word_d, miso_word_d;
  logic                  last_smp_d, adv_d, guard_done;

  always_comb begin
    // 0 and anything above DATA_WIDTH both mean a full-width word.
    if (bus.char_len == '0 || bus.char_len > DW_LEN) len_d = DW_LEN;
    else                                             len_d = bus.char_len;
    first_pos_d  = bus.lsb_first ? '0 : len_d - ONE;
    first_word_d = bus.tx_data >> first_pos_d;
    // The k-th bit on the wire sits at position k (LSB first) or N-1-k (MSB first).
    smp_pos_d    = lsb_q ? smp_cnt_q : len_q - ONE - smp_cnt_q;
    miso_word_d  = {{(DATA_WIDTH-1){1'b0}}, bus.miso} << smp_pos_d;
    smp_cnt_d    = smp_cnt_q + CNT_WIDTH'(bus.sample);
    last_smp_d   = bus.sample && (smp_cnt_q == len_q - ONE);
    shf_cnt_d    = shf_cnt_q + ONE;
    shf_pos_d    = lsb_q ? shf_cnt_d : len_q - ONE - shf_cnt_d;
    shf_word_d   = tx_q >> shf_pos_d;
    // Shift uses the post-sample count so a leading shift (CPHA-style) keeps the preloaded
    // bit; mosi freezes once the last bit is on the wire.
    adv_d        = bus.shift && (smp_cnt_d != '0) && (shf_cnt_q != len_q - ONE);
  end

`ifdef SPI_CS_GUARD_EN
  localparam int GUARD_EFF = (GUARD_CYCLES < 1) ? 1 : GUARD_CYCLES;
  localparam int GW        = $clog2(GUARD_EFF) + 1;
  logic [GW-1:0] guard_q;
  assign guard_done = (guard_q == GW'(GUARD_EFF - 1));
`else
  assign guard_done = 1'b1;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_q      <= '0;
      shadow_q  <= '0;
      rx_data_q <= '0;
      len_q     <= '0;
      smp_cnt_q <= '0;
      shf_cnt_q <= '0;
      lsb_q     <= 1'b0;
      ready_q   <= 1'b1;
      cs_n_q    <= 1'b1;
      tip_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_CS_GUARD_EN
      guard_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            tx_q      <= bus.tx_data;
            len_q     <= len_d;
            lsb_q     <= bus.lsb_first;
            shadow_q  <= '0;
            smp_cnt_q <= '0;
            shf_cnt_q <= '0;
            cs_n_q    <= 1'b0;
            ready_q   <= 1'b0;
            mosi_q    <= first_word_d[0];
            state_q   <= S_SETUP;
`ifdef SPI_CS_GUARD_EN
            guard_q   <= '0;
`endif
          end
        end
        S_SETUP: begin
          if (bus.abort) begin
            cs_n_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (guard_done) begin
            tip_q   <= 1'b1;
            state_q <= S_XFER;
          end else begin
`ifdef SPI_CS_GUARD_EN
            guard_q <= guard_q + 1'b1;
`endif
          end
        end
        S_XFER: begin
          if (bus.abort) begin
            tip_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            if (bus.sample) begin
              shadow_q  <= shadow_q | miso_word_d;
              smp_cnt_q <= smp_cnt_d;
            end
            if (adv_d) begin
              shf_cnt_q <= shf_cnt_d;
              mosi_q    <= shf_word_d[0];
            end
            if (last_smp_d) begin
              tip_q   <= 1'b0;
              state_q <= S_HOLD;
`ifdef SPI_CS_GUARD_EN
              guard_q <= '0;
`endif
            end
          end
        end
        S_HOLD: begin
          if (bus.abort) begin
            cs_n_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (guard_done) begin
            cs_n_q    <= 1'b1;
            done_q    <= 1'b1;
            rx_data_q <= shadow_q;
            ready_q   <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
`ifdef SPI_CS_GUARD_EN
            guard_q <= guard_q + 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.tip     = tip_q;
  assign bus.mosi    = mosi_q;
  assign bus.rx_data = rx_data_q;
  assign bus.done    = done_q;

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master clock generator. It accepts a word-transfer request, latches the payload, and drives chip select and TIP into the clock generator. It consumes the generator's shift and sample strobes to serialise MOSI and deserialise MISO, counts bits, and returns the received word with a done pulse. It sits between the register/host interface and the clock generator plus pads.

Parameters:
DATA_WIDTH, 32, maximum transfer length in bits; width of tx_data and rx_data.
CNT_WIDTH, 6, width of char_len and the internal bit counters; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
GUARD_CYCLES, 4, sys_clk cycles of CS setup and CS hold; used only with SPI_CS_GUARD_EN; 0 is treated as 1.

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  transfer request; sampled only while ready=1
abort  in  1  cancel the current transfer
tx_data  in  DATA_WIDTH  word to send; bits [char_len-1:0] are used
char_len  in  CNT_WIDTH  bits per transfer; 0 means DATA_WIDTH
lsb_first  in  1  1 = bit 0 first; 0 = bit char_len-1 first
shift  in  1  one-cycle strobe from the clock generator
sample  in  1  one-cycle strobe from the clock generator
miso  in  1  serial input, already synchronised
ready  out  1  idle and able to accept start
cs_n  out  1  chip select to the clock generator and pad, active low
tip  out  1  transfer in progress, to the clock generator
mosi  out  1  serial output
rx_data  out  DATA_WIDTH  last completed received word
done  out  1  one-cycle completion pulse

Behaviour:
- Reset values (immediate, asynchronous): ready=1, cs_n=1, tip=0, mosi=0, rx_data=0, done=0, FSM=IDLE, all counters 0. Reset during any state returns to these values at once.
- All outputs are registered.
- IDLE: ready=1. start=1 with abort=0 does the following:
  - latch tx_data, effective length N (1..DATA_WIDTH) and lsb_first;
  - clear the rx shadow register and the sample counter;
  - next cycle: cs_n=0, ready=0, mosi = first bit (tx[0] if lsb_first, else tx[N-1]); go to SETUP.
- SETUP: 1 cycle, or GUARD_CYCLES cycles with the feature. Then tip=1 and go to XFER.
- XFER, on a sample pulse: capture miso into the shadow register at the bit position matching its tx significance; increment the sample count.
- XFER, on a shift pulse: advance mosi to the next bit only if the sample count is greater than 0. A shift before the first sample is ignored, so the preloaded bit holds. This gives mode-agnostic CPHA handling.
- After the last bit, mosi holds its value.
- If sample and shift arrive in the same cycle, the sample is processed first, then the shift uses the updated count.
- On the Nth sample: next cycle tip=0; go to HOLD. Any later strobes are ignored.
- HOLD: 1 cycle, or GUARD_CYCLES cycles with the feature. On exit, in the same cycle: cs_n=1, done=1 for exactly one cycle, rx_data loaded from the shadow register (bits above N-1 are 0), ready=1; return to IDLE.
- abort in SETUP, XFER or HOLD: next cycle tip=0, cs_n=1, ready=1, IDLE. No done pulse; rx_data keeps its previous value. Abort takes priority over strobes in the same cycle. Abort in IDLE has no effect.
- start while ready=0 is ignored and is not queued.
- char_len greater than DATA_WIDTH is clamped to DATA_WIDTH.
- Latency with the feature off: start to tip=1 is 2 cycles; last sample to done is 2 cycles.

Optional Feature:
SPI_CS_GUARD_EN
- Defined: SETUP and HOLD each last GUARD_CYCLES sys_clk cycles, counted by a dedicated guard counter, to meet slave CS setup and hold timing.
- Undefined: SETUP and HOLD are one cycle each; no guard counter is synthesised.

Test Plan:
1. tx_data=0xA5, char_len=8, lsb_first=0, miso looped to mosi, shift-before-sample strobe order -> mosi at successive samples 1,0,1,0,0,1,0,1; rx_data=0x000000A5; exactly one done; cs_n=1 afterwards.
2. tx_data=0x01, char_len=8, lsb_first=1, sample-before-shift order, miso held at 1 -> mosi is 1 at the first sample and 0 at the rest; rx_data=0x000000FF.
3. char_len=0, tx_data=0xDEADBEEF, loopback -> 32 samples consumed; rx_data=0xDEADBEEF; tip low 1 cycle after the 32nd sample.
4. start pulsed during XFER with different tx_data -> ignored; ready=0 throughout; the first transfer's data is unchanged; only one done.
5. abort after 3 samples -> next cycle tip=0, cs_n=1, ready=1; no done; rx_data keeps its prior value.
6. rst asserted mid-XFER -> outputs take reset values immediately; a following start=1, char_len=4 completes normally.
